count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_mon_pkg.sv | 24 ++
 rtl/sat_counter.sv | 22 ++
 rtl/count_monitor.sv | 150 +++++++++++++++
 tb/tb_count_monitor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the counter monitor: state encoding,
// step direction codes and status bit positions.
package count_mon_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int EVT_W_DEF = 8;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam int STAT_OVF   = 0;
    localparam int STAT_UNF   = 1;
    localparam int STAT_MATCH = 2;
    localparam int STAT_JUMP  = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; an increment coincident with clear restarts at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Watches an up/down counter output and reports wraps, matches and jumps as
// registered pulses, sticky status, saturating event counts and an interrupt.
module count_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int EVT_W = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             ld_in,
    input  logic             mon_en,
    input  logic [CNT_W-1:0] match_val,
    input  logic [3:0]       irq_mask,
    input  logic             clr,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             match_pulse,
    output logic             jump_pulse,
    output logic [1:0]       dir_out,
    output logic [EVT_W-1:0] ovf_cnt,
    output logic [EVT_W-1:0] unf_cnt,
    output logic [3:0]       status,
    output logic             irq
);

    state_t           state;
    state_t           state_nx;
    dir_t             dir_q;
    logic [CNT_W-1:0] prev;
    logic [CNT_W-1:0] delta;
    logic             step_up;
    logic             step_dn;
    logic             ev_ovf;
    logic             ev_unf;
    logic             ev_match;
    logic             ev_jump;
    logic [3:0]       events;

    assign delta   = cnt_in - prev;
    assign dir_out = dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!mon_en) begin
            state_nx = ST_INIT;
        end else begin
            case (state)
                ST_INIT:  state_nx = ST_TRACK;
                ST_TRACK: state_nx = ST_TRACK;
                default:  state_nx = ST_INIT;
            endcase
        end
    end

    // Step decode: a load overrides the arithmetic delta, and INIT samples
    // only seed prev (no step class), though they can still match.
    always_comb begin
        step_up  = 1'b0;
        step_dn  = 1'b0;
        ev_ovf   = 1'b0;
        ev_unf   = 1'b0;
        ev_match = 1'b0;
        ev_jump  = 1'b0;
        if (mon_en) begin
            case (state)
                ST_INIT: begin
                    ev_match = (cnt_in == match_val);
                end
                ST_TRACK: begin
                    ev_match = (cnt_in == match_val) && (prev != match_val);
                    if (ld_in) begin
                        ev_jump = 1'b1;
                    end else if (delta == CNT_W'(1)) begin
                        step_up = 1'b1;
                    end else if (delta == '1) begin
                        step_dn = 1'b1;
                    end else if (delta != '0) begin
                        ev_jump = 1'b1;
                    end
                    ev_ovf = step_up && (prev == '1);
                    ev_unf = step_dn && (prev == '0);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        events             = '0;
        events[STAT_OVF]   = ev_ovf;
        events[STAT_UNF]   = ev_unf;
        events[STAT_MATCH] = ev_match;
        events[STAT_JUMP]  = ev_jump;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= '0;
            dir_q       <= DIR_NONE;
            ovf_pulse   <= 1'b0;
            unf_pulse   <= 1'b0;
            match_pulse <= 1'b0;
            jump_pulse  <= 1'b0;
            status      <= '0;
            irq         <= 1'b0;
        end else begin
            if (mon_en) begin
                prev <= cnt_in;
            end
            if (step_up) begin
                dir_q <= DIR_UP;
            end else if (step_dn) begin
                dir_q <= DIR_DOWN;
            end
            ovf_pulse   <= ev_ovf;
            unf_pulse   <= ev_unf;
            match_pulse <= ev_match;
            jump_pulse  <= ev_jump;
            status      <= clr ? events : (status | events);
            irq         <= |(status & irq_mask);
        end
    end

    sat_counter #(.W(EVT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_ovf),
        .clr   (clr),
        .count (ovf_cnt)
    );

    sat_counter #(.W(EVT_W)) u_unf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ev_unf),
        .clr   (clr),
        .count (unf_cnt)
    );

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt_in;
    logic       ld_in;
    logic       mon_en;
    logic [3:0] match_val;
    logic [3:0] irq_mask;
    logic       clr;
    logic       ovf_pulse, unf_pulse, match_pulse, jump_pulse;
    logic [1:0] dir_out;
    logic [7:0] ovf_cnt, unf_cnt;
    logic [3:0] status;
    logic       irq;

    typedef struct {
        int unsigned due;
        string       name;
        logic [3:0]  p;
        logic [1:0]  dir;
        logic [7:0]  oc;
        logic [7:0]  uc;
        logic [3:0]  st;
        logic        irq;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    count_monitor #(.CNT_W(4), .EVT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cnt_in      (cnt_in),
        .ld_in       (ld_in),
        .mon_en      (mon_en),
        .match_val   (match_val),
        .irq_mask    (irq_mask),
        .clr         (clr),
        .ovf_pulse   (ovf_pulse),
        .unf_pulse   (unf_pulse),
        .match_pulse (match_pulse),
        .jump_pulse  (jump_pulse),
        .dir_out     (dir_out),
        .ovf_cnt     (ovf_cnt),
        .unf_cnt     (unf_cnt),
        .status      (status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due <= cyc) begin
            e_mon = q.pop_front();
            if (e_mon.due != cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missed actual_cycle=%0d expected_cycle=%0d", e_mon.name, cyc, e_mon.due);
            end else begin
                chk(e_mon.name, "pulses", {28'd0, jump_pulse, match_pulse, unf_pulse, ovf_pulse}, {28'd0, e_mon.p});
                chk(e_mon.name, "dir", {30'd0, dir_out}, {30'd0, e_mon.dir});
                chk(e_mon.name, "ovf_cnt", {24'd0, ovf_cnt}, {24'd0, e_mon.oc});
                chk(e_mon.name, "unf_cnt", {24'd0, unf_cnt}, {24'd0, e_mon.uc});
                chk(e_mon.name, "status", {28'd0, status}, {28'd0, e_mon.st});
                chk(e_mon.name, "irq", {31'd0, irq}, {31'd0, e_mon.irq});
            end
        end
    end

    // Drive one sample; optionally queue the outputs expected after its edge.
    task automatic samp(input logic en, input logic [3:0] c, input logic ld, input bit push,
                        input string nm, input logic [3:0] p, input logic [1:0] d,
                        input logic [7:0] oc, input logic [7:0] uc, input logic [3:0] st,
                        input logic i);
        exp_t e;
        mon_en = en;
        cnt_in = c;
        ld_in  = ld;
        if (push) begin
            e.due = cyc + 1; e.name = nm; e.p = p; e.dir = d;
            e.oc = oc; e.uc = uc; e.st = st; e.irq = i;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic en, input logic [3:0] c, input logic ld);
        samp(en, c, ld, 1'b0, "", '0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0; cnt_in = '0; ld_in = 1'b0; mon_en = 1'b0;
        match_val = 4'd7; irq_mask = 4'b0000; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state, then a wrap through 15 -> 0
        samp(0, 0, 0, 1, "reset",  4'b0000, 2'b00, 0, 0, 4'b0000, 0);
        samp(1, 13, 0, 1, "a13",   4'b0000, 2'b00, 0, 0, 4'b0000, 0);
        samp(1, 14, 0, 1, "a14",   4'b0000, 2'b01, 0, 0, 4'b0000, 0);
        samp(1, 15, 0, 1, "a15",   4'b0000, 2'b01, 0, 0, 4'b0000, 0);
        samp(1, 0, 0, 1, "a0_ovf", 4'b0001, 2'b01, 1, 0, 4'b0001, 0);

        // underflow with irq on status bit 1
        irq_mask = 4'b0010;
        samp(1, 1, 0, 1, "b1",      4'b0000, 2'b01, 1, 0, 4'b0001, 0);
        samp(1, 0, 0, 1, "b0",      4'b0000, 2'b10, 1, 0, 4'b0001, 0);
        samp(1, 15, 0, 1, "b15unf", 4'b0010, 2'b10, 1, 1, 4'b0011, 0);
        samp(1, 15, 0, 1, "b_hold", 4'b0000, 2'b10, 1, 1, 4'b0011, 1);

        // jumps: large delta, then a unit step under load
        samp(1, 3, 0, 1, "c3",     4'b1000, 2'b10, 1, 1, 4'b1011, 1);
        samp(1, 9, 0, 1, "c9",     4'b1000, 2'b10, 1, 1, 4'b1011, 1);
        samp(1, 10, 1, 1, "c10ld", 4'b1000, 2'b10, 1, 1, 4'b1011, 1);

        clr = 1'b1;
        samp(0, 0, 0, 1, "clr_off", 4'b0000, 2'b10, 0, 0, 4'b0000, 1);
        clr = 1'b0;

        // match on entry to 5 only
        match_val = 4'd5;
        samp(1, 4, 0, 1, "d4",    4'b0000, 2'b10, 0, 0, 4'b0000, 0);
        samp(1, 5, 0, 1, "d5a",   4'b0100, 2'b01, 0, 0, 4'b0100, 0);
        samp(1, 5, 0, 1, "d5rep", 4'b0000, 2'b01, 0, 0, 4'b0100, 0);
        samp(1, 6, 0, 1, "d6",    4'b0000, 2'b01, 0, 0, 4'b0100, 0);
        samp(1, 5, 0, 1, "d5b",   4'b0100, 2'b10, 0, 0, 4'b0100, 0);

        // 300 overflows via load-to-15 then step to 0
        clr = 1'b1;
        step(0, 0, 0);
        clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1, 15, 1);
            if (i == 254 || i == 299)
                samp(1, 0, 0, 1, "sat", 4'b0001, 2'b01, 255, 0, 4'b1001, 0);
            else
                step(1, 0, 0);
        end
        step(1, 15, 1);
        clr = 1'b1;
        samp(1, 0, 0, 1, "clr_wins", 4'b0001, 2'b01, 1, 0, 4'b0001, 0);
        clr = 1'b0;

        // mid-run reset: 15 right after release must not be classified
        step(1, 14, 1);
        rst_n = 1'b0;
        samp(0, 0, 0, 1, "reset_mid", 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
        rst_n = 1'b1;
        samp(1, 15, 0, 1, "post_rst15", 4'b0000, 2'b00, 0, 0, 4'b0000, 0);
        samp(1, 0, 0, 1, "post_rst0",   4'b0001, 2'b01, 1, 0, 4'b0001, 0);

        // disable holds state and re-enters INIT
        samp(0, 1, 0, 1, "en_off", 4'b0000, 2'b01, 1, 0, 4'b0001, 0);
        samp(1, 2, 0, 1, "reinit", 4'b0000, 2'b01, 1, 0, 4'b0001, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("drain", "queue", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
